yd_lsu: RTL and testbench
=========================

# yd_lsu

Load/store unit for the Yduck core. It sits between instruction decode and the register file on one side and the external data bus on the other. It takes the data-bus address from the register file's `DKD` output and raises `dsv` so the register file holds `PC` while an access is pending. It runs a request/acknowledge transaction on the data bus and returns load data through register-file write port 1 (`din1`/`waddr1`/`we1`).

## Interface

Parameters:
- `TIMEOUT`, default 255: maximum number of `REQ` cycles without `bus_ack` before the access is aborted. Legal range 2..65535. Used only with `YD_LSU_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ls_req` in 1: decode issues a load or store this cycle.
- `ls_we` in 1: 1 = store, 0 = load.
- `ls_rd` in 4: load destination register address (register-file encoding).
- `ls_wdata` in 16: store data.
- `dkd` in 16: access address, taken from the register file's `DKD` output.
- `dsv` out 1: data-bus access in progress; the register file holds `PC` while it is high.
- `bus_req` out 1: bus request.
- `bus_we` out 1: bus write strobe.
- `bus_addr` out 16: bus address.
- `bus_wdata` out 16: bus write data.
- `bus_ack` in 1: bus acknowledge; read data is valid in the same cycle.
- `bus_rdata` in 16: bus read data.
- `wb_we` out 1: to register file `we1`.
- `wb_addr` out 4: to register file `waddr1`.
- `wb_data` out 16: to register file `din1`.
- `ls_err` out 1: one-cycle pulse when an access times out.

## Operation

- FSM has three states: `IDLE`, `REQ`, `WB`.
- **Accept:** a request is accepted when the state is `IDLE` or `WB` and `ls_req` = 1.
  - On accept, `dkd`, `ls_we`, `ls_wdata` and `ls_rd` are captured into internal registers.
  - The next state is `REQ`.
  - `ls_req` in `REQ` is ignored, because decode is stalled by `dsv`.
- **REQ:**
  - Outputs: `bus_req` = 1; `bus_addr`, `bus_we` and `bus_wdata` come from the captured registers.
  - Load with `bus_ack` = 1: `bus_rdata` is captured into `wb_data` and the next state is `WB`.
  - Store with `bus_ack` = 1: the next state is `IDLE`.
  - `bus_ack` = 0: the FSM stays in `REQ`.
- **WB:**
  - Outputs: `wb_we` = 1, `wb_addr` = captured `ls_rd`, `wb_data` = captured load data, for exactly one cycle.
  - Next state is `IDLE`, or `REQ` if a new request is accepted in the same cycle.
  - A load to address 0 is still written back; the register file discards it.
- **dsv** = (`ls_req` & state ∈ {`IDLE`, `WB`}) | (state == `REQ`). It is combinational.
- All bus outputs and `wb_*` outputs are registered. `bus_we` and `bus_wdata` are 0 whenever `bus_req` = 0.
- `bus_ack` outside `REQ` is ignored.

## Timing

- Reset (asynchronous, immediate, including mid-access):
  - State goes to `IDLE`; all captured registers are cleared.
  - `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `wb_we`, `wb_addr`, `wb_data` and `ls_err` are all 0.
  - `dsv` follows its combinational equation from `ls_req`.
  - An in-flight bus transaction is abandoned without completion.
- Load with `bus_ack` in the first `REQ` cycle:
  - c0: accept, `dsv` = 1.
  - c1: `REQ`, `bus_req` = 1, ack.
  - c2: `WB`, `wb_we` = 1, `dsv` = 0.
  - A minimum load is 3 cycles, of which 2 are stalled.
- Store with an immediate ack:
  - c0: accept.
  - c1: `REQ`, ack.
  - c2: `IDLE`.
  - That is 2 stalled cycles.
- Each wait cycle without `bus_ack` adds one `REQ` cycle and one stall cycle.
- Back-to-back: a request in the `WB` cycle makes the next cycle `REQ`, with no bubble.

## Configuration

- Macro: `YD_LSU_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit counter clears on entry to `REQ` and increments on each `REQ` cycle without ack.
  - When the count equals `TIMEOUT`-1 and `bus_ack` = 0, the access is aborted: `bus_req` drops on the next edge and `ls_err` pulses for 1 cycle (coincident with `WB` for loads).
  - After an aborted load, the FSM goes to `WB` with `wb_data` = 16'hFFFF.
  - After an aborted store, the FSM goes to `IDLE`.
  - An ack arriving on the abort cycle wins, and the access completes normally.
- **Undefined:**
  - `REQ` waits indefinitely.
  - `ls_err` is tied to 0.
  - No counter is built.

## Structure

- Shared package `yd_pkg` holds:
  - state encoding `LSU_IDLE`=2'd0, `LSU_REQ`=2'd1, `LSU_WB`=2'd2;
  - constant `LSU_ERR_DATA`=16'hFFFF.
- One sub-module, `yd_lsu_wdog`: the timeout counter.
  - Inputs: clear, count enable.
  - Output: expire.
  - It is instantiated only under `YD_LSU_TIMEOUT_EN`.

## Test plan

- Load at `dkd`=16'h0040, `ls_rd`=4'h3, ack in 1st `REQ` cycle with `bus_rdata`=16'hBEEF -> c1 `bus_req`=1, `bus_addr`=16'h0040, `bus_we`=0; c2 `wb_we`=1, `wb_addr`=3, `wb_data`=16'hBEEF; `dsv` high c0–c1 only.
- Store at 16'h0100 with `ls_wdata`=16'h1234, ack delayed 3 cycles -> `bus_we`=1, `bus_wdata`=16'h1234 held 4 `REQ` cycles; `dsv` high 5 cycles; no `wb_we`.
- Load followed by `ls_req` in its `WB` cycle -> the next cycle is `REQ` with the new address; `wb_we` pulses exactly once.
- Reset asserted during `REQ` -> `bus_req` falls without waiting for a clock edge; all outputs 0; the first request after release behaves normally.
- With `YD_LSU_TIMEOUT_EN` and `TIMEOUT`=4, load with no ack -> `bus_req` high 4 cycles, `ls_err` 1 pulse, `wb_data`=16'hFFFF; ack on the 4th cycle -> normal completion with no `ls_err`.

Source files
------------

// File: rtl/yd_pkg.sv
// Shared Yduck definitions: load/store unit state encoding and the data
// substituted for a load that was aborted by the bus watchdog.
package yd_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WB   = 2'd2
  } lsu_state_e;

  localparam logic [15:0] LSU_ERR_DATA = 16'hFFFF;

endpackage

// File: rtl/yd_lsu_wdog.sv
// Bus watchdog for yd_lsu: counts REQ cycles without acknowledge and flags
// expiry once TIMEOUT-1 such cycles have elapsed (used with YD_LSU_TIMEOUT_EN).
module yd_lsu_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 16'd0;
    end else if (clr) begin
      cnt <= 16'd0;
    end else if (en) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expire = (cnt == 16'(TIMEOUT - 1));

endmodule

// File: rtl/yd_lsu.sv
// Yduck load/store unit: request/acknowledge data-bus master with load
// write-back to register-file port 1. Optional watchdog: YD_LSU_TIMEOUT_EN.
module yd_lsu
  import yd_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [3:0]  ls_rd,
  input  logic [15:0] ls_wdata,
  input  logic [15:0] dkd,
  output logic        dsv,
  output logic        bus_req,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata,
  output logic        wb_we,
  output logic [3:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic        ls_err
);

  lsu_state_e  state;
  logic [3:0]  rd_q;
  logic        accept;
  logic        in_req;
  logic        abort;

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("yd_lsu: TIMEOUT out of range 2..65535");
  end

  assign in_req = (state == LSU_REQ);
  assign accept = ls_req && (state == LSU_IDLE || state == LSU_WB);
  // Decode stalls from the accept cycle until the bus access leaves REQ.
  assign dsv    = accept || in_req;

`ifdef YD_LSU_TIMEOUT_EN
  logic expire;

  yd_lsu_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .en     (in_req && !bus_ack),
    .expire (expire)
  );

  assign abort = in_req && !bus_ack && expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls_err <= 1'b0;
    end else begin
      ls_err <= abort;
    end
  end
`else
  assign abort  = 1'b0;
  assign ls_err = 1'b0;
`endif

  // Bus outputs double as the captured address/write-enable/data and are
  // cleared whenever no request is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LSU_IDLE;
      rd_q      <= 4'd0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 16'd0;
      bus_wdata <= 16'd0;
      wb_we     <= 1'b0;
      wb_addr   <= 4'd0;
      wb_data   <= 16'd0;
    end else begin
      wb_we   <= 1'b0;
      wb_addr <= 4'd0;
      wb_data <= 16'd0;
      case (state)
        LSU_REQ: begin
          if (bus_ack || abort) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 16'd0;
            bus_wdata <= 16'd0;
            if (!bus_we) begin
              state   <= LSU_WB;
              wb_we   <= 1'b1;
              wb_addr <= rd_q;
              wb_data <= bus_ack ? bus_rdata : LSU_ERR_DATA;
            end else begin
              state <= LSU_IDLE;
            end
          end
        end
        default: begin
          if (accept) begin
            state     <= LSU_REQ;
            rd_q      <= ls_rd;
            bus_req   <= 1'b1;
            bus_we    <= ls_we;
            bus_addr  <= dkd;
            bus_wdata <= ls_we ? ls_wdata : 16'd0;
          end else begin
            state <= LSU_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_yd_lsu.sv
// Self-checking bench for yd_lsu: scoreboard queues of expected bus requests
// and write-backs, one task per scenario.
module tb_yd_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_rd;
  logic [15:0] ls_wdata;
  logic [15:0] dkd;
  logic        dsv;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_ack;
  logic [15:0] bus_rdata;
  logic        wb_we;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        ls_err;

  int vectors = 0;
  int errors  = 0;

  logic [19:0] exp_wb[$];   // {wb_addr, wb_data}
  logic [32:0] exp_bus[$];  // {bus_we, bus_addr, bus_wdata}

  yd_lsu #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_rd     (ls_rd),
    .ls_wdata  (ls_wdata),
    .dkd       (dkd),
    .dsv       (dsv),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .ls_err    (ls_err)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_rd = 4'h0;
    ls_wdata = 16'h0; dkd = 16'h0; bus_ack = 1'b0; bus_rdata = 16'h0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, wb_we, wb_addr, wb_data, ls_err} !== 55'd0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h wb_we=%b wb_addr=%h wb_data=%h err=%b, expected all 0",
               bus_req, bus_we, bus_addr, bus_wdata, wb_we, wb_addr, wb_data, ls_err);
    end
    vectors++;
    if (dsv !== 1'b0) begin errors++; $display("FAIL reset_dsv_idle: got %b expected 0", dsv); end
    ls_req = 1'b1;
    #1;
    vectors++;
    if (dsv !== 1'b1) begin errors++; $display("FAIL reset_dsv_req: got %b expected 1", dsv); end
    ls_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // bus_ack while idle must be ignored
    @(posedge clk); #1; bus_ack = 1'b1; bus_rdata = 16'h5555;
    @(negedge clk);
    @(posedge clk); #1; bus_ack = 1'b0; bus_rdata = 16'h0;
    @(negedge clk);
    vectors++;
    if ({bus_req, wb_we, dsv} !== 3'b000) begin
      errors++;
      $display("FAIL idle_ack_ignored: got req=%b wb_we=%b dsv=%b expected 000", bus_req, wb_we, dsv);
    end
  endtask

  task automatic do_load(input string nm, input logic [15:0] a, input logic [3:0] rd,
                         input logic [15:0] d);
    logic [32:0] b;
    logic [19:0] e;
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = 1'b0; dkd = a; ls_rd = rd; ls_wdata = 16'h0;
    exp_bus.push_back({1'b0, a, 16'h0});
    exp_wb.push_back({rd, d});
    @(negedge clk);
    vectors++;
    if (dsv !== 1'b1) begin errors++; $display("FAIL %s_dsv_c0: got %b expected 1", nm, dsv); end
    @(posedge clk); #1;
    ls_req = 1'b0; dkd = 16'hDEAD; ls_rd = 4'hF; bus_ack = 1'b1; bus_rdata = d;
    @(negedge clk);
    b = exp_bus.pop_front();
    vectors++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, dsv} !== {1'b1, b, 1'b1}) begin
      errors++;
      $display("FAIL %s_c1: got req=%b we=%b addr=%h wdata=%h dsv=%b expected req=1 we/addr/wdata=%h dsv=1",
               nm, bus_req, bus_we, bus_addr, bus_wdata, dsv, b);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = 16'h0;
    @(negedge clk);
    vectors++;
    if (wb_we !== 1'b1) begin
      errors++; $display("FAIL %s_wb_we: got %b expected 1", nm, wb_we);
    end else begin
      e = exp_wb.pop_front();
      vectors++;
      if ({wb_addr, wb_data} !== e) begin
        errors++; $display("FAIL %s_wb_data: got %h_%h expected %h", nm, wb_addr, wb_data, e);
      end
    end
    vectors++;
    if ({dsv, bus_req, ls_err} !== 3'b000) begin
      errors++; $display("FAIL %s_c2_ctrl: got dsv=%b req=%b err=%b expected 000", nm, dsv, bus_req, ls_err);
    end
    @(negedge clk);
    vectors++;
    if (wb_we !== 1'b0) begin errors++; $display("FAIL %s_wb_once: got %b expected 0", nm, wb_we); end
  endtask

  task automatic test_load();
    do_load("load", 16'h0040, 4'h3, 16'hBEEF);
    do_load("load2", 16'hFFFE, 4'hC, 16'h0001);
  endtask

  task automatic test_store_wait();
    logic [32:0] b;
    int n_dsv = 0, n_req = 0, n_wb = 0, n_bad = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      ls_req = (n == 0); ls_we = 1'b1; dkd = (n == 0) ? 16'h0100 : 16'h7777;
      ls_wdata = (n == 0) ? 16'h1234 : 16'h9999; ls_rd = 4'h0;
      bus_ack = (n == 4);
      if (n == 0) exp_bus.push_back({1'b1, 16'h0100, 16'h1234});
      @(negedge clk);
      if (dsv) n_dsv++;
      if (wb_we) n_wb++;
      if (bus_req) begin
        n_req++;
        if ({bus_we, bus_addr, bus_wdata} !== exp_bus[0]) n_bad++;
      end else if (bus_we || bus_wdata != 16'h0) begin
        n_bad++;
      end
    end
    bus_ack = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    b = exp_bus.pop_front();
    vectors++;
    if (n_req != 4) begin errors++; $display("FAIL store_req_cycles: got %0d expected 4", n_req); end
    vectors++;
    if (n_dsv != 5) begin errors++; $display("FAIL store_dsv_cycles: got %0d expected 5", n_dsv); end
    vectors++;
    if (n_wb != 0) begin errors++; $display("FAIL store_no_wb: got %0d expected 0", n_wb); end
    vectors++;
    if (n_bad != 0) begin
      errors++; $display("FAIL store_bus_fields: got %0d bad cycles expected 0 (want %h)", n_bad, b);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] e;
    int n_wb = 0;
    exp_wb.push_back({4'h5, 16'hA5A5});
    for (int n = 0; n < 7; n++) begin
      @(posedge clk); #1;
      ls_req = (n == 0) || (n == 2);
      ls_we = (n == 2); dkd = (n == 0) ? 16'h0200 : 16'h0300;
      ls_rd = 4'h5; ls_wdata = 16'h7777;
      bus_ack = (n == 1) || (n == 3); bus_rdata = (n == 1) ? 16'hA5A5 : 16'h0;
      @(negedge clk);
      if (wb_we) begin
        n_wb++;
        e = exp_wb.pop_front();
        vectors++;
        if ({wb_addr, wb_data} !== e) begin
          errors++; $display("FAIL b2b_wb_data: got %h_%h expected %h", wb_addr, wb_data, e);
        end
      end
      if (n == 2) begin
        vectors++;
        if ({wb_we, dsv} !== 2'b11) begin
          errors++; $display("FAIL b2b_wb_cycle: got wb_we=%b dsv=%b expected 11", wb_we, dsv);
        end
      end
      if (n == 3) begin
        vectors++;
        if ({bus_req, bus_we, bus_addr, bus_wdata} !== {1'b1, 1'b1, 16'h0300, 16'h7777}) begin
          errors++; $display("FAIL b2b_next_req: got req=%b we=%b addr=%h wdata=%h expected 1 1 0300 7777",
                             bus_req, bus_we, bus_addr, bus_wdata);
        end
      end
    end
    ls_req = 1'b0; bus_ack = 1'b0;
    vectors++;
    if (n_wb != 1) begin errors++; $display("FAIL b2b_wb_count: got %0d expected 1", n_wb); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = 1'b0; dkd = 16'h0400; ls_rd = 4'h2;
    @(posedge clk); #1;
    ls_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus_req !== 1'b1) begin errors++; $display("FAIL mid_pre_req: got %b expected 1", bus_req); end
    #2; rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, wb_we, wb_addr, wb_data, ls_err, dsv} !== 56'd0) begin
      errors++;
      $display("FAIL mid_async_reset: got req=%b we=%b addr=%h wb_we=%b wb_data=%h dsv=%b expected all 0",
               bus_req, bus_we, bus_addr, wb_we, wb_data, dsv);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_load("after_rst", 16'h0060, 4'h0, 16'h0BAD);
  endtask

`ifdef YD_LSU_TIMEOUT_EN
  task automatic test_timeout(input string nm, input int ack_at, input logic [15:0] rdat,
                              input logic [15:0] want, input int want_err);
    logic [19:0] e;
    int n_req = 0, n_err = 0, n_wb = 0;
    exp_wb.push_back({4'h7, want});
    for (int n = 0; n < 9; n++) begin
      @(posedge clk); #1;
      ls_req = (n == 0); ls_we = 1'b0; dkd = 16'h0500; ls_rd = 4'h7;
      bus_ack = (n == ack_at); bus_rdata = rdat;
      @(negedge clk);
      if (bus_req) n_req++;
      if (ls_err) n_err++;
      if (wb_we) begin
        n_wb++;
        e = exp_wb.pop_front();
        vectors++;
        if ({wb_addr, wb_data, ls_err} !== {e, (want_err != 0)}) begin
          errors++; $display("FAIL %s_wb: got %h_%h err=%b expected %h err=%0d", nm, wb_addr, wb_data, ls_err, e, want_err);
        end
      end
    end
    ls_req = 1'b0; bus_ack = 1'b0;
    vectors++;
    if (n_req != 4) begin errors++; $display("FAIL %s_req_cycles: got %0d expected 4", nm, n_req); end
    vectors++;
    if (n_err != want_err) begin errors++; $display("FAIL %s_err_pulses: got %0d expected %0d", nm, n_err, want_err); end
    vectors++;
    if (n_wb != 1) begin errors++; $display("FAIL %s_wb_count: got %0d expected 1", nm, n_wb); end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_store_wait();
    test_back_to_back();
    test_reset_mid();
`ifdef YD_LSU_TIMEOUT_EN
    test_timeout("tmo_abort", 99, 16'h0, 16'hFFFF, 1);
    test_timeout("tmo_ack4", 4, 16'h1111, 16'h1111, 0);
`endif
    vectors++;
    if (exp_wb.size() != 0 || exp_bus.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got wb=%0d bus=%0d expected 0 0", exp_wb.size(), exp_bus.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
